// File: rtl/hbridge_monitor.sv
// hbridge_monitor
// Receive-side monitor for a 4-bit H-bridge gate bus. It synchronises the bus and
// measures forward/reverse duty over fixed windows. It also flags sticky faults:
// shoot-through (illegal gate patterns) and dead-time violations.
module hbridge_monitor #(
    parameter int WIN_POW   = 16,
    parameter int DUTY_BITS = 10,
    parameter int MIN_DEAD  = 50
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           hb_in,
    input  logic                 clear_fault,
    output logic [DUTY_BITS-1:0] duty_fwd,
    output logic [DUTY_BITS-1:0] duty_rev,
    output logic                 active,
    output logic                 sample_valid,
    output logic                 fault_shoot,
    output logic                 fault_dead
);

    localparam int SHIFT = WIN_POW - DUTY_BITS;
    localparam logic [WIN_POW:0]     DUTY_MAX_W = (WIN_POW+1)'((1 << DUTY_BITS) - 1);
    localparam logic [DUTY_BITS-1:0] DUTY_MAX   = '1;
    localparam logic [6:0]           MIN_DEAD_C = 7'(MIN_DEAD);

    typedef enum logic [1:0] {CLS_IDLE, CLS_FWD, CLS_REV, CLS_ILL} cls_t;
    typedef enum logic [1:0] {POL_NONE, POL_FWD, POL_REV} pol_t;
    typedef enum logic [1:0] {ST_IDLE_GAP, ST_DRV_FWD, ST_DRV_REV} state_t;

    // Synchroniser and classification
    logic [3:0] r_sync1;
    logic [3:0] r_hs;
    cls_t       w_cls;
    logic       w_is_fwd;
    logic       w_is_rev;
    logic       w_is_ill;

    // Window measurement
    logic [WIN_POW-1:0]   r_win_cnt;
    logic [WIN_POW:0]     r_fwd_cnt;
    logic [WIN_POW:0]     r_rev_cnt;
    logic                 w_win_end;
    logic [WIN_POW:0]     w_fwd_total;
    logic [WIN_POW:0]     w_rev_total;
    logic [WIN_POW:0]     w_fwd_q;
    logic [WIN_POW:0]     w_rev_q;
    logic [DUTY_BITS-1:0] w_fwd_duty;
    logic [DUTY_BITS-1:0] w_rev_duty;
    logic [DUTY_BITS-1:0] r_duty_fwd;
    logic [DUTY_BITS-1:0] r_duty_rev;
    logic                 r_active;
    logic                 r_sample_valid;

    // Dead-time tracking
    state_t     r_state;
    pol_t       r_last_pol;
    logic [6:0] r_gap_cnt;
    logic       w_viol;

    // Faults
    logic r_fault_shoot;
    logic r_fault_dead;

    // Two-stage synchroniser for the asynchronous gate bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_hs    <= '0;
        end else begin
            r_sync1 <= hb_in;
            r_hs    <= r_sync1;
        end
    end

    // Decode the synchronised gate pattern into a bus class
    always_comb begin
        w_cls = CLS_ILL;
        case (r_hs)
            4'b0000: w_cls = CLS_IDLE;
            4'b1001: w_cls = CLS_FWD;
            4'b0110: w_cls = CLS_REV;
            default: w_cls = CLS_ILL;
        endcase
    end

    assign w_is_fwd  = (w_cls == CLS_FWD);
    assign w_is_rev  = (w_cls == CLS_REV);
    assign w_is_ill  = (w_cls == CLS_ILL);
    assign w_win_end = &r_win_cnt;

    // The last cycle of a window still counts, so it is folded into the totals here
    assign w_fwd_total = r_fwd_cnt + {{WIN_POW{1'b0}}, w_is_fwd};
    assign w_rev_total = r_rev_cnt + {{WIN_POW{1'b0}}, w_is_rev};
    assign w_fwd_q     = w_fwd_total >> SHIFT;
    assign w_rev_q     = w_rev_total >> SHIFT;

    // A fully driven window scales to one past full scale, so clamp it
    assign w_fwd_duty = (w_fwd_q > DUTY_MAX_W) ? DUTY_MAX : w_fwd_q[DUTY_BITS-1:0];
    assign w_rev_duty = (w_rev_q > DUTY_MAX_W) ? DUTY_MAX : w_rev_q[DUTY_BITS-1:0];

    // Free-running window counter with per-polarity cycle accumulation and result capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win_cnt      <= '0;
            r_fwd_cnt      <= '0;
            r_rev_cnt      <= '0;
            r_duty_fwd     <= '0;
            r_duty_rev     <= '0;
            r_active       <= 1'b0;
            r_sample_valid <= 1'b0;
        end else begin
            r_win_cnt      <= r_win_cnt + 1'b1;
            r_sample_valid <= w_win_end;
            if (w_win_end) begin
                r_duty_fwd <= w_fwd_duty;
                r_duty_rev <= w_rev_duty;
                r_active   <= (|w_fwd_total) | (|w_rev_total);
                r_fwd_cnt  <= '0;
                r_rev_cnt  <= '0;
            end else begin
                if (w_is_fwd) r_fwd_cnt <= r_fwd_cnt + 1'b1;
                if (w_is_rev) r_rev_cnt <= r_rev_cnt + 1'b1;
            end
        end
    end

    // A polarity reversal is a violation when it comes straight from driving,
    // or after too short an idle gap. A monitor that has never seen drive accepts anything.
    always_comb begin
        w_viol = 1'b0;
        if (w_is_fwd) begin
            w_viol = (r_state == ST_DRV_REV) ||
                     ((r_state == ST_IDLE_GAP) && (r_last_pol == POL_REV) && (r_gap_cnt < MIN_DEAD_C));
        end else if (w_is_rev) begin
            w_viol = (r_state == ST_DRV_FWD) ||
                     ((r_state == ST_IDLE_GAP) && (r_last_pol == POL_FWD) && (r_gap_cnt < MIN_DEAD_C));
        end
    end

    // Dead-time FSM: tracks the current drive state, the last polarity and the idle gap length
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE_GAP;
            r_last_pol <= POL_NONE;
            r_gap_cnt  <= '0;
        end else begin
            case (w_cls)
                CLS_IDLE: begin
                    if (r_state != ST_IDLE_GAP) begin
                        r_state   <= ST_IDLE_GAP;
                        r_gap_cnt <= 7'd1;
                    end else if (r_gap_cnt < MIN_DEAD_C) begin
                        r_gap_cnt <= r_gap_cnt + 7'd1;
                    end
                end
                CLS_FWD: begin
                    r_state    <= ST_DRV_FWD;
                    r_last_pol <= POL_FWD;
                end
                CLS_REV: begin
                    r_state    <= ST_DRV_REV;
                    r_last_pol <= POL_REV;
                end
                default: begin
                    // An illegal pattern does not count as idle time, so the gap restarts
                    r_state   <= ST_IDLE_GAP;
                    r_gap_cnt <= '0;
                end
            endcase
        end
    end

    // Sticky fault flags; a fresh event beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fault_shoot <= 1'b0;
            r_fault_dead  <= 1'b0;
        end else begin
            if (w_is_ill)         r_fault_shoot <= 1'b1;
            else if (clear_fault) r_fault_shoot <= 1'b0;
            if (w_viol)           r_fault_dead  <= 1'b1;
            else if (clear_fault) r_fault_dead  <= 1'b0;
        end
    end

    assign duty_fwd     = r_duty_fwd;
    assign duty_rev     = r_duty_rev;
    assign active       = r_active;
    assign sample_valid = r_sample_valid;
    assign fault_shoot  = r_fault_shoot;
    assign fault_dead   = r_fault_dead;

endmodule

// File: tb/tb_hbridge_monitor.sv
// Directed testbench for hbridge_monitor (WIN_POW=8, DUTY_BITS=4, MIN_DEAD=4).
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_hbridge_monitor;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear_fault;
    logic [3:0] hb_in;
    logic [3:0] duty_fwd;
    logic [3:0] duty_rev;
    logic       active;
    logic       sample_valid;
    logic       fault_shoot;
    logic       fault_dead;

    int checks = 0;
    int errors = 0;
    int n;
    int n_valid;
    logic [31:0] got_fwd;
    logic [31:0] got_rev;
    logic [31:0] got_act;

    hbridge_monitor #(
        .WIN_POW  (8),
        .DUTY_BITS(4),
        .MIN_DEAD (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hb_in       (hb_in),
        .clear_fault (clear_fault),
        .duty_fwd    (duty_fwd),
        .duty_rev    (duty_rev),
        .active      (active),
        .sample_valid(sample_valid),
        .fault_shoot (fault_shoot),
        .fault_dead  (fault_dead)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-18s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance n falling edges, capturing any window result that appears
    task automatic tick(input int n_cyc);
        repeat (n_cyc) begin
            @(negedge clk);
            if (sample_valid) begin
                got_fwd = 32'(duty_fwd);
                got_rev = 32'(duty_rev);
                got_act = 32'(active);
                n_valid++;
            end
        end
    endtask

    task automatic drive(input logic [3:0] pat, input int n_cyc);
        hb_in = pat;
        tick(n_cyc);
    endtask

    task automatic pulse_clear();
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        tick(1);
    endtask

    // Count falling edges until sample_valid is seen (bounded)
    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!sample_valid && cnt < 1000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        hb_in       = 4'b0000;
        clear_fault = 1'b0;
        reset_n     = 1'b1;
        n_valid     = 0;
        got_fwd     = '0;
        got_rev     = '0;
        got_act     = '0;
        #2 reset_n  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_duty_fwd", 32'(duty_fwd), 0);
        check("rst_duty_rev", 32'(duty_rev), 0);
        check("rst_active", 32'(active), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_shoot", 32'(fault_shoot), 0);
        check("rst_dead", 32'(fault_dead), 0);

        // 1. constant forward drive saturates duty_fwd
        reset_n = 1'b1;
        hb_in   = 4'b1001;
        wait_valid(n);
        check("first_valid_lat", 32'(n), 256);
        wait_valid(n);
        check("fwd_period", 32'(n), 256);
        check("fwd_duty_fwd", 32'(duty_fwd), 15);
        check("fwd_duty_rev", 32'(duty_rev), 0);
        check("fwd_active", 32'(active), 1);
        @(negedge clk);
        check("valid_one_cycle", 32'(sample_valid), 0);

        // 2. 64 reverse cycles per 256-cycle window
        n_valid = 0;
        repeat (3) begin
            drive(4'b0000, 192);
            drive(4'b0110, 64);
        end
        check("rev_windows", 32'(n_valid), 3);
        check("rev_duty_rev", got_rev, 4);
        check("rev_duty_fwd", got_fwd, 0);
        check("rev_active", got_act, 1);
        check("rev_no_shoot", 32'(fault_shoot), 0);
        check("rev_no_dead", 32'(fault_dead), 0);

        // 3. dead-time gap lengths 2, 3 (violations) and 4 (legal)
        drive(4'b0000, 10);
        drive(4'b1001, 5);
        drive(4'b0000, 2);
        drive(4'b0110, 5);
        drive(4'b0000, 6);
        check("dead_gap2", 32'(fault_dead), 1);
        check("dead_no_shoot", 32'(fault_shoot), 0);
        pulse_clear();
        check("dead_cleared", 32'(fault_dead), 0);
        drive(4'b1001, 5);
        drive(4'b0000, 3);
        drive(4'b0110, 5);
        drive(4'b0000, 6);
        check("dead_gap3", 32'(fault_dead), 1);
        pulse_clear();
        drive(4'b1001, 5);
        drive(4'b0000, 4);
        drive(4'b0110, 5);
        drive(4'b0000, 6);
        check("dead_gap4", 32'(fault_dead), 0);

        // 4. one-cycle illegal pattern, latency and stickiness
        drive(4'b1100, 1);
        drive(4'b0000, 1);
        check("shoot_early", 32'(fault_shoot), 0);
        tick(1);
        check("shoot_latency", 32'(fault_shoot), 1);
        tick(10);
        check("shoot_held", 32'(fault_shoot), 1);
        pulse_clear();
        check("shoot_cleared", 32'(fault_shoot), 0);

        // 5. clear_fault coincident with a direct forward->reverse flip
        drive(4'b0000, 10);
        drive(4'b1001, 5);
        drive(4'b0110, 2);
        check("flip_pre", 32'(fault_dead), 0);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        check("clear_vs_event", 32'(fault_dead), 1);

        // 6. reset mid-window at win_cnt == 100
        wait_valid(n);
        check("t6_sync", 32'(sample_valid), 1);
        repeat (100) @(negedge clk);
        check("pre_rst_dead", 32'(fault_dead), 1);
        reset_n = 1'b0;
        hb_in   = 4'b0000;
        #1;
        check("mid_rst_duty_fwd", 32'(duty_fwd), 0);
        check("mid_rst_duty_rev", 32'(duty_rev), 0);
        check("mid_rst_active", 32'(active), 0);
        check("mid_rst_valid", 32'(sample_valid), 0);
        check("mid_rst_shoot", 32'(fault_shoot), 0);
        check("mid_rst_dead", 32'(fault_dead), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_valid(n);
        check("restart_latency", 32'(n), 256);
        check("idle_active", 32'(active), 0);
        check("idle_duty_fwd", 32'(duty_fwd), 0);
        check("idle_duty_rev", 32'(duty_rev), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
